// File: rtl/mem_access_unit_if.sv
// Pipeline-side and data-memory-side signals of the MEM stage access unit.
// The unit itself uses the master view; the pipeline/memory environment uses slave.
interface mem_access_unit_if;
  logic [3:0]  mem_read_in;
  logic [2:0]  mem_write_in;
  logic [31:0] addr_in;
  logic [31:0] wdata_in;
  logic        busy_out;
  logic [31:0] load_data_out;
  logic        load_valid_out;
  logic        err_out;
  logic [1:0]  err_code_out;
  logic        mem_req_out;
  logic        mem_we_out;
  logic [31:0] mem_addr_out;
  logic [3:0]  mem_be_out;
  logic [31:0] mem_wdata_out;
  logic [31:0] mem_rdata_in;
  logic        mem_ack_in;

  modport master (
    input  mem_read_in, mem_write_in, addr_in, wdata_in, mem_rdata_in, mem_ack_in,
    output busy_out, load_data_out, load_valid_out, err_out, err_code_out,
    output mem_req_out, mem_we_out, mem_addr_out, mem_be_out, mem_wdata_out
  );

  modport slave (
    output mem_read_in, mem_write_in, addr_in, wdata_in, mem_rdata_in, mem_ack_in,
    input  busy_out, load_data_out, load_valid_out, err_out, err_code_out,
    input  mem_req_out, mem_we_out, mem_addr_out, mem_be_out, mem_wdata_out
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: one req/ack word-bus access per op, DONE one cycle after ack.
// Stalls the pipeline (busy_out) from op arrival until the access completes, errors or times out.
module mem_access_unit #(
  parameter int MAX_WAIT = 255
) (
  input logic               clk,
  input logic               rst,
  mem_access_unit_if.master bus
);

  localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_inc;
  logic          r_we;
  logic          r_unsigned;
  logic [1:0]    r_size;
  logic [31:0]   r_addr;
  logic [3:0]    r_be;
  logic [31:0]   r_wdata;
  logic [31:0]   r_load_data;
  logic          r_load_vld;
  logic          r_err;
  logic [1:0]    r_err_code;

  logic          w_is_ld, w_is_st, w_op;
  logic [2:0]    w_f3;
  logic [1:0]    w_size;
  logic          w_illegal, w_misalign, w_timeout, w_req;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic [7:0]    w_lane8;
  logic [15:0]   w_lane16;
  logic [31:0]   w_extract;
  logic          w_busy, w_latch, w_err_set, w_load_done;
  logic [1:0]    w_err_code;

  assign w_is_ld = bus.mem_read_in[3];
  assign w_is_st = bus.mem_write_in[2];
  assign w_op    = w_is_ld | w_is_st;
  assign w_f3    = bus.mem_read_in[2:0];
  assign w_size  = w_is_ld ? w_f3[1:0] : bus.mem_write_in[1:0];

  assign w_illegal = (w_is_ld & w_is_st)
                   | (w_is_ld & (w_f3 == 3'b011 || w_f3 == 3'b110 || w_f3 == 3'b111))
                   | (w_is_st & (bus.mem_write_in[1:0] == 2'b11));
  assign w_misalign = ((w_size == 2'b01) & bus.addr_in[0])
                    | ((w_size == 2'b10) & (bus.addr_in[1:0] != 2'b00));

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = bus.wdata_in;
    case (w_size)
      2'b00: begin
        w_be    = 4'b0001 << bus.addr_in[1:0];
        w_wdata = {4{bus.wdata_in[7:0]}};
      end
      2'b01: begin
        w_be    = bus.addr_in[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{bus.wdata_in[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane selection uses the offset latched at issue, not the live addr_in.
  always_comb begin
    w_lane8 = bus.mem_rdata_in[7:0];
    case (r_addr[1:0])
      2'b01:   w_lane8 = bus.mem_rdata_in[15:8];
      2'b10:   w_lane8 = bus.mem_rdata_in[23:16];
      2'b11:   w_lane8 = bus.mem_rdata_in[31:24];
      default: ;
    endcase
    w_lane16 = r_addr[1] ? bus.mem_rdata_in[31:16] : bus.mem_rdata_in[15:0];
    case (r_size)
      2'b00:   w_extract = r_unsigned ? {24'b0, w_lane8} : {{24{w_lane8[7]}}, w_lane8};
      2'b01:   w_extract = r_unsigned ? {16'b0, w_lane16} : {{16{w_lane16[15]}}, w_lane16};
      default: w_extract = bus.mem_rdata_in;
    endcase
  end

  assign w_cnt_inc = r_cnt + CW'(1);
  assign w_timeout = (MAX_WAIT != 0) && (w_cnt_inc == CW'(MAX_WAIT));

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_latch     = 1'b0;
    w_err_set   = 1'b0;
    w_err_code  = 2'b00;
    w_load_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_op) begin
          w_busy = 1'b1;
          if (w_illegal) begin
            w_state_nxt = S_DONE;
            w_err_set   = 1'b1;
            w_err_code  = 2'b10;
          end else if (w_misalign) begin
            w_state_nxt = S_DONE;
            w_err_set   = 1'b1;
            w_err_code  = 2'b01;
          end else begin
            w_state_nxt = S_REQ;
            w_latch     = 1'b1;
          end
        end
      end
      S_REQ: begin
        w_busy = 1'b1;
        // An ack arriving on the timeout cycle still completes the access.
        if (bus.mem_ack_in) begin
          w_state_nxt = S_DONE;
          w_load_done = ~r_we;
        end else if (w_timeout) begin
          w_state_nxt = S_DONE;
          w_err_set   = 1'b1;
          w_err_code  = 2'b11;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_unsigned  <= 1'b0;
      r_size      <= 2'b00;
      r_addr      <= '0;
      r_be        <= '0;
      r_wdata     <= '0;
      r_load_data <= '0;
      r_load_vld  <= 1'b0;
      r_err       <= 1'b0;
      r_err_code  <= 2'b00;
    end else begin
      r_state    <= w_state_nxt;
      r_load_vld <= w_load_done;
      r_err      <= w_err_set;
      r_cnt      <= (r_state == S_REQ) ? w_cnt_inc : '0;
      if (w_err_set)   r_err_code  <= w_err_code;
      if (w_load_done) r_load_data <= w_extract;
      if (w_latch) begin
        r_we       <= w_is_st;
        r_unsigned <= w_f3[2];
        r_size     <= w_size;
        r_addr     <= bus.addr_in;
        r_be       <= w_be;
        r_wdata    <= w_wdata;
      end
    end
  end

  assign w_req              = (r_state == S_REQ);
  assign bus.busy_out       = w_busy;
  assign bus.mem_req_out    = w_req;
  assign bus.mem_we_out     = w_req & r_we;
  assign bus.mem_addr_out   = w_req ? {r_addr[31:2], 2'b00} : 32'h0;
  assign bus.mem_be_out     = w_req ? r_be : 4'h0;
  assign bus.mem_wdata_out  = w_req ? r_wdata : 32'h0;
  assign bus.load_data_out  = r_load_data;
  assign bus.load_valid_out = r_load_vld;
  assign bus.err_out        = r_err;
  assign bus.err_code_out   = r_err_code;

endmodule
